// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write-only responder: state encoding,
// default device address and the address-frame match helper.
package i2c_pkg;

    // Address used when the instantiating design does not override it.
    localparam logic [6:0] DEFAULT_DEVICE_ADDRESS = 7'h50;

    // Protocol position of the responder within a bus transaction.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDRESS   = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_DATA      = 3'd3,
        ST_DATA_ACK  = 3'd4,
        ST_IGNORE    = 3'd5
    } state_e;

    // A frame is ours only when the 7-bit address matches and it is a write;
    // reads are not supported, so a read to our address is treated as foreign.
    function automatic logic addr_frame_match(input logic [7:0] frame,
                                              input logic [6:0] dev_addr);
        return (frame[7:1] == dev_addr) && !frame[0];
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer for one raw bus line, plus single-cycle rise and
// fall pulses derived from the synchronized level.
module i2c_line_sync (
    input  logic Clock,
    input  logic Reset,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain plus one history flop for edge detection.
    always_ff @(posedge Clock or negedge Reset) begin
        // NOTE: reset to 1 (idle bus level) so releasing reset on a quiet bus
        // produces no phantom edge; state updates use <= so the chain shifts
        // one stage per clock regardless of statement order.
        if (!Reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_line;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/i2c_responder.sv
// Write-only I2C responder: detects START/STOP, matches a 7-bit address,
// acknowledges address and data bytes, and presents each received byte
// on DataOut with a one-cycle DataValid pulse.
module i2c_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] DeviceAddress = DEFAULT_DEVICE_ADDRESS
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       SCL,
    input  logic       SDA,
    output logic       SDAPullDown,
    output logic [7:0] DataOut,
    output logic       DataValid,
    output logic       Addressed,
    output logic       Busy
);

    // Synchronized bus lines and their edge pulses.
    logic w_scl;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_sda;
    logic w_sda_rise;
    logic w_sda_fall;

    i2c_line_sync u_scl_sync (
        .Clock   (Clock),
        .Reset   (Reset),
        .i_line  (SCL),
        .o_level (w_scl),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .Clock   (Clock),
        .Reset   (Reset),
        .i_line  (SDA),
        .o_level (w_sda),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    // Bus conditions: SDA may only change while SCL is high for START/STOP.
    logic w_start;
    logic w_stop;
    assign w_start = w_sda_fall & w_scl;
    assign w_stop  = w_sda_rise & w_scl;

    // Registered state.
    state_e     r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_pull;
    logic [7:0] r_data_out;
    logic       r_data_valid;
    logic       r_addressed;
    logic       r_busy;

    // Next-state values.
    state_e     w_next_state;
    logic [2:0] w_next_bit_cnt;
    logic [7:0] w_next_shift;
    logic       w_next_pull;
    logic [7:0] w_next_data_out;
    logic       w_next_data_valid;
    logic       w_next_addressed;
    logic       w_next_busy;

    // Byte as it will look once the current SDA bit is shifted in.
    logic [7:0] w_frame;
    logic       w_last_bit;
    assign w_frame    = {r_shift[6:0], w_sda};
    assign w_last_bit = (r_bit_cnt == 3'd7);

    // Next-state and output decode; START outranks STOP, which outranks bit handling.
    always_comb begin
        // NOTE: every target gets a hold/default value first so no path through
        // the case statement leaves a signal unassigned and infers a latch.
        w_next_state      = r_state;
        w_next_bit_cnt    = r_bit_cnt;
        w_next_shift      = r_shift;
        w_next_pull       = r_pull;
        w_next_data_out   = r_data_out;
        w_next_data_valid = 1'b0;
        w_next_addressed  = r_addressed;
        w_next_busy       = r_busy;

        if (w_start) begin
            w_next_state     = ST_ADDRESS;
            w_next_bit_cnt   = 3'd0;
            w_next_pull      = 1'b0;
            w_next_addressed = 1'b0;
            w_next_busy      = 1'b1;
        end else if (w_stop) begin
            w_next_state     = ST_IDLE;
            w_next_bit_cnt   = 3'd0;
            w_next_pull      = 1'b0;
            w_next_addressed = 1'b0;
            w_next_busy      = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    // Wait for START; all other bus activity is ignored.
                end

                ST_ADDRESS: begin
                    if (w_scl_rise) begin
                        w_next_shift   = w_frame;
                        w_next_bit_cnt = r_bit_cnt + 3'd1;
                        if (w_last_bit) begin
                            w_next_state = addr_frame_match(w_frame, DeviceAddress)
                                         ? ST_ADDR_ACK : ST_IGNORE;
                        end
                    end
                end

                ST_DATA: begin
                    if (w_scl_rise) begin
                        w_next_shift   = w_frame;
                        w_next_bit_cnt = r_bit_cnt + 3'd1;
                        if (w_last_bit) begin
                            w_next_data_out   = w_frame;
                            w_next_data_valid = 1'b1;
                            w_next_state      = ST_DATA_ACK;
                        end
                    end
                end

                ST_ADDR_ACK, ST_DATA_ACK: begin
                    // First SCL fall ends bit 8 and starts the ACK slot;
                    // the second one ends the ACK slot.
                    if (w_scl_fall) begin
                        if (!r_pull) begin
                            w_next_pull = 1'b1;
                        end else begin
                            w_next_pull  = 1'b0;
                            w_next_state = ST_DATA;
                            if (r_state == ST_ADDR_ACK) begin
                                w_next_addressed = 1'b1;
                            end
                        end
                    end
                end

                ST_IGNORE: begin
                    // Foreign address or read request: stay silent.
                end

                default: begin
                    w_next_state = ST_IDLE;
                    w_next_pull  = 1'b0;
                end
            endcase
        end
    end

    // Single clocked process holding FSM state, counter, shifter and outputs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_pull       <= 1'b0;
            r_data_out   <= 8'h00;
            r_data_valid <= 1'b0;
            r_addressed  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_bit_cnt    <= w_next_bit_cnt;
            r_shift      <= w_next_shift;
            r_pull       <= w_next_pull;
            r_data_out   <= w_next_data_out;
            r_data_valid <= w_next_data_valid;
            r_addressed  <= w_next_addressed;
            r_busy       <= w_next_busy;
        end
    end

    assign SDAPullDown = r_pull;
    assign DataOut     = r_data_out;
    assign DataValid   = r_data_valid;
    assign Addressed   = r_addressed;
    assign Busy        = r_busy;

endmodule

// File: tb/tb_i2c_responder.sv
// Self-checking bench for i2c_responder: a bit-banged bus master drives
// directed and random write/read transactions; a transaction-level model
// predicts ACKs, received bytes, DataOut and status outputs.
module tb_i2c_responder;

    localparam int         Q   = 6;      // clocks per quarter SCL period
    localparam logic [6:0] DEV = 7'h50;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       scl    = 1'b1;
    logic       m_sda  = 1'b1;
    logic       sda_line;
    logic       pd;
    logic       dv;
    logic       addressed;
    logic       busy;
    logic [7:0] dout;

    // Open-drain wired-AND of master and responder.
    assign sda_line = m_sda & ~pd;

    always #5 clk = ~clk;

    i2c_responder #(.DeviceAddress(DEV)) dut (
        .Clock       (clk),
        .Reset       (rst_n),
        .SCL         (scl),
        .SDA         (sda_line),
        .SDAPullDown (pd),
        .DataOut     (dout),
        .DataValid   (dv),
        .Addressed   (addressed),
        .Busy        (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor state.
    logic [7:0] got_q[$];
    int         pd_cycles = 0;
    int         dv_long   = 0;
    logic       dv_prev   = 1'b0;

    // Model state.
    logic [7:0] exp_q[$];
    logic [7:0] last_data = 8'h00;
    logic [7:0] tx_data[4];

    // Observe outputs on the falling clock edge, away from the active edge.
    always @(negedge clk) begin
        if (dv) got_q.push_back(dout);
        if (pd) pd_cycles++;
        if (dv && dv_prev) dv_long++;
        dv_prev = dv;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    // START (also used as repeated START from SCL low).
    task automatic bus_start();
        m_sda = 1'b1; wait_q();
        scl   = 1'b1; wait_q();
        m_sda = 1'b0; wait_q();
        scl   = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wait_q();
        scl   = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    wait_q();
        scl   = 1'b1; wait_q(); wait_q();
        scl   = 1'b0; wait_q();
    endtask

    // Ninth clock: master releases SDA and samples it mid-high.
    task automatic ack_bit(output bit acked);
        m_sda = 1'b1; wait_q();
        scl   = 1'b1; wait_q();
        acked = (sda_line == 1'b0);
        wait_q();
        scl   = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output bit acked);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        ack_bit(acked);
    endtask

    // One transaction segment. Ends with STOP (and full checks) unless
    // abort_bits > 0, in which case a partial byte is followed by a repeated START.
    task automatic txn(input logic [6:0] addr, input bit rw, input int nb,
                       input int abort_bits, input logic [7:0] abort_byte,
                       input bit do_start);
        bit ack_exp;
        bit seen;
        int pd_entry;
        ack_exp  = (addr == DEV) && !rw;
        pd_entry = pd_cycles;
        if (do_start) bus_start();
        check("busy_after_start", busy, 1);
        send_byte({addr, rw}, seen);
        check("addr_ack", seen, ack_exp);
        for (int i = 0; i < nb; i++) begin
            send_byte(tx_data[i], seen);
            check("data_ack", seen, ack_exp);
            check("addressed_in_txn", addressed, ack_exp);
            if (ack_exp) begin
                exp_q.push_back(tx_data[i]);
                last_data = tx_data[i];
            end
        end
        if (!ack_exp) check("no_pulldown", pd_cycles - pd_entry, 0);
        if (abort_bits > 0) begin
            for (int i = 0; i < abort_bits; i++) send_bit(abort_byte[7 - i]);
            bus_start();
            check("addressed_after_rstart", addressed, 0);
            check("busy_after_rstart", busy, 1);
        end else begin
            bus_stop();
            wait_q();
            check("busy_after_stop", busy, 0);
            check("addressed_after_stop", addressed, 0);
            check("data_out", dout, last_data);
            check("valid_count", got_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
                check("valid_byte", got_q[i], exp_q[i]);
            check("valid_width", dv_long, 0);
            got_q.delete();
            exp_q.delete();
        end
    endtask

    initial begin
        bit chained;
        bit seen;
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_pulldown", pd, 0);
        check("rst_valid", dv, 0);
        check("rst_dataout", dout, 8'h00);
        check("rst_addressed", addressed, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        wait_q();

        // Basic write with one byte.
        tx_data[0] = 8'hA5;
        txn(7'h50, 1'b0, 1, 0, 8'h00, 1'b1);
        // Foreign address.
        tx_data[0] = 8'h3C;
        txn(7'h51, 1'b0, 1, 0, 8'h00, 1'b1);
        // Read request to our address.
        tx_data[0] = 8'h99;
        txn(7'h50, 1'b1, 1, 0, 8'h00, 1'b1);
        // Multi-byte write.
        tx_data[0] = 8'h01; tx_data[1] = 8'hFF; tx_data[2] = 8'h80;
        txn(7'h50, 1'b0, 3, 0, 8'h00, 1'b1);
        // Partial byte aborted by repeated START, then a full write.
        txn(7'h50, 1'b0, 0, 4, 8'hC3, 1'b1);
        tx_data[0] = 8'h7E;
        txn(7'h50, 1'b0, 1, 0, 8'h00, 1'b0);

        // Randomized transactions.
        chained = 1'b0;
        for (int t = 0; t < 24; t++) begin
            logic [6:0] addr;
            bit         rw;
            int         nb;
            int         ab;
            addr = ($urandom_range(0, 3) == 0) ? 7'($urandom) : DEV;
            rw   = ($urandom_range(0, 4) == 0);
            nb   = $urandom_range(0, 3);
            ab   = (t != 23 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            for (int i = 0; i < 4; i++) tx_data[i] = 8'($urandom);
            txn(addr, rw, nb, ab, 8'($urandom), !chained);
            chained = (ab > 0);
        end

        // Reset asserted while ACK is being driven.
        bus_start();
        send_byte({DEV, 1'b0}, seen);
        check("rstack_addr_ack", seen, 1);
        for (int i = 7; i >= 0; i--) send_bit(i[0]);
        m_sda = 1'b1;
        wait_q();
        check("rstack_pd_before", pd, 1);
        rst_n = 1'b0;
        #1;
        check("rstack_pd", pd, 0);
        check("rstack_valid", dv, 0);
        check("rstack_dataout", dout, 8'h00);
        check("rstack_addressed", addressed, 0);
        check("rstack_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_q.delete();
        pd_cycles = 0;
        dv_long   = 0;
        scl = 1'b1; wait_q(); wait_q();
        scl = 1'b0; wait_q();
        send_byte(8'h5A, seen);
        check("post_rst_nack", seen, 0);
        check("post_rst_no_pd", pd_cycles, 0);
        check("post_rst_no_valid", got_q.size(), 0);
        check("post_rst_busy", busy, 0);
        bus_stop();
        wait_q();
        check("post_rst_dataout", dout, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_responder.md
I2C_RESPONDER -- requirements
Module: i2c_responder

Interface
REQ-001 SHALL have parameter DeviceAddress, default 7'h50, 7-bit address this responder acknowledges.
REQ-002 SHALL have port Clock  input  1  system clock; all flops on rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port SCL  input  1  raw I2C clock line.
REQ-005 SHALL have port SDA  input  1  raw I2C data line, sampled.
REQ-006 SHALL have port SDAPullDown  output  1  1 = drive SDA low (open-drain), 0 = release.
REQ-007 SHALL have port DataOut  output  8  last received data byte.
REQ-008 SHALL have port DataValid  output  1  one-Clock pulse when DataOut is updated.
REQ-009 SHALL have port Addressed  output  1  high from ACKed address until STOP or START.
REQ-010 SHALL have port Busy  output  1  high between detected START and STOP.

Function
REQ-011 SHALL pass SCL and SDA through 2-flop synchronizers; all decisions use synchronized values; synchronized edges are 1-cycle pulses.
REQ-012 SHALL detect START as synchronized SDA falling while synchronized SCL high; STOP as SDA rising while SCL high.
REQ-013 SHALL implement states Idle, Address, AddrAck, Data, DataAck, Ignore.
REQ-014 SHALL, on START in any state (incl. repeated START), enter Address, clear bit counter to 0, clear Addressed, release SDA.
REQ-015 SHALL, on STOP in any state, enter Idle, release SDA, clear Addressed and Busy.
REQ-016 SHALL sample SDA MSB-first on each synchronized SCL rising edge in Address and Data; 3-bit counter wraps 7->0 after the 8th bit.
REQ-017 SHALL, after the 8th Address bit, compare bits[7:1] to DeviceAddress; match with bit0=0 (write) -> AddrAck; mismatch or bit0=1 (read unsupported) -> Ignore.
REQ-018 SHALL assert SDAPullDown on the SCL falling edge ending bit 8 and release it on the following SCL falling edge, in AddrAck and DataAck.
REQ-019 SHALL leave AddrAck for Data and set Addressed on the release edge of REQ-018.
REQ-020 SHALL, after the 8th Data bit, load DataOut and pulse DataValid for exactly one Clock in the cycle after the 8th SCL rising edge is detected, then enter DataAck.
REQ-021 SHALL leave DataAck for Data on the release edge; unlimited bytes per transaction.
REQ-022 SHALL, in Ignore, never assert SDAPullDown and never pulse DataValid until START or STOP.
REQ-023 SHALL hold DataOut between updates; partial bytes aborted by START/STOP are discarded and DataOut is unchanged.
REQ-024 SHALL treat START/STOP during an asserted ACK as releasing SDA in the same cycle.
REQ-025 SHALL give START priority over bit sampling when both are detected in one cycle (not possible on legal bus; defined for determinism).

Reset
REQ-026 SHALL, while Reset=0, force state Idle, counter 0, SDAPullDown=0, DataOut=8'h00, DataValid=0, Addressed=0, Busy=0, synchronizers to 1 (idle bus).
REQ-027 SHALL ignore bus activity until a START is seen after Reset deasserts; reset mid-transfer drops the transaction.

Structure
REQ-028 SHALL place state encoding (3-bit) and default DeviceAddress constant in shared package i2c_pkg.
REQ-029 SHALL use sub-module i2c_line_sync (2-flop sync plus rise/fall pulse outputs), instantiated for SCL and SDA.
REQ-030 SHALL keep next-state logic combinational and state/counter/shift register in one clocked process.

Verification
REQ-031 Write to 7'h50, byte 8'hA5, STOP -> ACK low during 9th SCL of address and data, DataOut=8'hA5, one DataValid pulse, Addressed 1 then 0 after STOP.
REQ-032 Write to 7'h51, byte 8'h3C -> SDAPullDown never asserted, no DataValid, Addressed stays 0.
REQ-033 Read request address 7'h50, R/W=1 -> NACK (SDA released on 9th clock), state Ignore until STOP.
REQ-034 Write 7'h50, bytes 8'h01, 8'hFF, 8'h80 -> three DataValid pulses, DataOut sequence 01, FF, 80, each ACKed.
REQ-035 Write 7'h50, 4 bits of 8'hC3 then repeated START, write 7'h50 byte 8'h7E -> no pulse for partial byte, DataOut=8'h7E.
REQ-036 Reset=0 asserted while SDAPullDown=1 during ACK -> SDAPullDown=0 immediately, all outputs at reset values, next byte without START ignored.
